// File: rtl/key_event.sv
// Turns a debounced button level into one-cycle press/release/click/long/repeat events.
// Define KEY_REPEAT_EN to build in the auto-repeat counter and the rpt pulse; otherwise rpt is tied to 0.
module key_event #(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press,
  output logic rel,
  output logic click,
  output logic long,
  output logic rpt,
  output logic held
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_MS - 1);
  localparam logic [CW-1:0] CNT_SAT   = '1;

  // Elaboration-time range guard for all timing parameters.
  if (TICK_DIV < 1 || TICK_DIV > 65535 || LONG_MS < 1 || LONG_MS > 65535 ||
      REPEAT_MS < 1 || REPEAT_MS > 65535) begin : g_param_range
    $error("key_event: TICK_DIV/LONG_MS/REPEAT_MS must be in 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_LONG  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          key_s, key_d;
  logic [CW-1:0] div_cnt, div_nxt;
  logic [CW-1:0] hold_cnt, hold_nxt;
  logic          press_nxt, rel_nxt, click_nxt, long_nxt, held_nxt;
  logic          rise, fall, tick;

`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_MS - 1);
  logic [CW-1:0] rep_cnt, rep_nxt;
  logic          rpt_nxt;
`endif

  // key is sampled once, then compared with its previous sample: events land on the 2nd edge.
  assign rise = key_s & ~key_d;
  assign fall = ~key_s & key_d;
  assign tick = (div_cnt == TICK_LAST);

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    click_nxt = 1'b0;
    long_nxt  = 1'b0;
    div_nxt   = tick ? '0 : div_cnt + CW'(1);
    hold_nxt  = hold_cnt;
`ifdef KEY_REPEAT_EN
    rpt_nxt   = 1'b0;
    rep_nxt   = rep_cnt;
`endif
    if (tick && (state != S_IDLE) && (hold_cnt != CNT_SAT)) begin
      hold_nxt = hold_cnt + CW'(1);
    end

    case (state)
      S_IDLE: begin
        if (rise) begin
          state_nxt = S_PRESS;
          press_nxt = 1'b1;
          div_nxt   = '0;
          hold_nxt  = '0;
        end
      end
      S_PRESS: begin
        if (fall) begin
          state_nxt = S_IDLE;
          rel_nxt   = 1'b1;
          click_nxt = 1'b1;
        end else if (tick && (hold_cnt == LONG_LAST)) begin
          state_nxt = S_LONG;
          long_nxt  = 1'b1;
`ifdef KEY_REPEAT_EN
          rep_nxt   = '0;
`endif
        end
      end
      S_LONG: begin
        if (fall) begin
          state_nxt = S_IDLE;
          rel_nxt   = 1'b1;
        end
`ifdef KEY_REPEAT_EN
        else if (tick) begin
          if (rep_cnt == REP_LAST) begin
            rpt_nxt = 1'b1;
            rep_nxt = '0;
          end else begin
            rep_nxt = rep_cnt + CW'(1);
          end
        end
`endif
      end
      default: state_nxt = S_IDLE;
    endcase

    held_nxt = (state_nxt != S_IDLE);
  end

  // State, counters and registered outputs; key samples reset high so a held key gives no press.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_s    <= 1'b1;
      key_d    <= 1'b1;
      state    <= S_IDLE;
      div_cnt  <= '0;
      hold_cnt <= '0;
      press    <= 1'b0;
      rel      <= 1'b0;
      click    <= 1'b0;
      long     <= 1'b0;
      held     <= 1'b0;
    end else begin
      key_s    <= key;
      key_d    <= key_s;
      state    <= state_nxt;
      div_cnt  <= div_nxt;
      hold_cnt <= hold_nxt;
      press    <= press_nxt;
      rel      <= rel_nxt;
      click    <= click_nxt;
      long     <= long_nxt;
      held     <= held_nxt;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt <= '0;
      rpt     <= 1'b0;
    end else begin
      rep_cnt <= rep_nxt;
      rpt     <= rpt_nxt;
    end
  end
`else
  assign rpt = 1'b0;
`endif

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event (TICK_DIV=4, LONG_MS=5, REPEAT_MS=3); outputs sampled on the falling edge.
module tb_key_event;

  logic clk, rst, key;
  logic press, rel, click, long, rpt, held;

  int checks = 0;
  int errors = 0;

  // Expected vectors: {press, rel, click, long, rpt, held}
  localparam logic [5:0] E_IDLE = 6'b000000;
  localparam logic [5:0] E_PRS  = 6'b100001;
  localparam logic [5:0] E_HLD  = 6'b000001;
  localparam logic [5:0] E_RELC = 6'b011000;
  localparam logic [5:0] E_REL  = 6'b010000;
  localparam logic [5:0] E_LNG  = 6'b000101;
`ifdef KEY_REPEAT_EN
  localparam logic [5:0] E_RPT  = 6'b000011;
`else
  localparam logic [5:0] E_RPT  = 6'b000001;
`endif

  key_event #(.TICK_DIV(4), .LONG_MS(5), .REPEAT_MS(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .key   (key),
    .press (press),
    .rel   (rel),
    .click (click),
    .long  (long),
    .rpt   (rpt),
    .held  (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    @(negedge clk);
    obs = {press, rel, click, long, rpt, held};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    logic [5:0] e;
    rst = 1'b1;
    key = 1'b0;
    repeat (3) chk("reset_state", E_IDLE);
    rst = 1'b0;
    // key low at reset exit looks like a fall in IDLE: must stay silent
    repeat (4) chk("idle_after_reset", E_IDLE);

    // Short press: key high 10 cycles
    key = 1'b1;
    chk("short_latency", E_IDLE);
    chk("short_press", E_PRS);
    repeat (8) chk("short_held", E_HLD);
    key = 1'b0;
    chk("short_held_tail", E_HLD);
    chk("short_release_click", E_RELC);
    repeat (3) chk("short_idle", E_IDLE);

    // Long hold: long at P+20, rpt every 12 cycles from P+32, release at P+100
    key = 1'b1;
    chk("long_latency", E_IDLE);
    chk("long_press", E_PRS);
    for (int c = 1; c <= 101; c++) begin
      if (c == 20)                         e = E_LNG;
      else if (c == 100)                   e = E_REL;
      else if (c == 101)                   e = E_IDLE;
      else if (c > 20 && (c - 20) % 12 == 0) e = E_RPT;
      else                                 e = E_HLD;
      chk("long_hold", e);
      if (c == 98) key = 1'b0;
    end

    // Race: fall reaches the FSM on the threshold tick -> release+click, no long
    key = 1'b1;
    chk("race_latency", E_IDLE);
    chk("race_press", E_PRS);
    for (int c = 1; c <= 21; c++) begin
      if (c == 20)      e = E_RELC;
      else if (c == 21) e = E_IDLE;
      else              e = E_HLD;
      chk("race", e);
      if (c == 18) key = 1'b0;
    end

    // Reset while held: no release, no press from the still-high key
    key = 1'b1;
    chk("rst_latency", E_IDLE);
    chk("rst_press", E_PRS);
    repeat (9) chk("rst_held", E_HLD);
    rst = 1'b1;
    chk("rst_mid_drop", E_IDLE);
    chk("rst_mid_hold", E_IDLE);
    rst = 1'b0;
    repeat (10) chk("rst_key_high", E_IDLE);
    key = 1'b0;
    repeat (4) chk("rst_fall_ignored", E_IDLE);
    key = 1'b1;
    chk("rst_next_latency", E_IDLE);
    chk("rst_next_press", E_PRS);
    chk("rst_next_held", E_HLD);
    key = 1'b0;
    chk("rst_next_held_tail", E_HLD);
    chk("rst_next_release", E_RELC);
    repeat (2) chk("rst_next_idle", E_IDLE);

    // Toggle 1,0,1 on consecutive cycles
    key = 1'b1;
    chk("tog_latency", E_IDLE);
    key = 1'b0;
    chk("tog_press", E_PRS);
    key = 1'b1;
    chk("tog_release", E_RELC);
    chk("tog_press2", E_PRS);
    key = 1'b0;
    chk("tog_held", E_HLD);
    chk("tog_release2", E_RELC);
    repeat (2) chk("tog_idle", E_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
